// File: rtl/ps2_pkg.sv
// Shared types and sizing helpers for the PS/2 event queue.
// Channel indices name the fixed keyboard/mouse decoder slots.
package ps2_pkg;

  localparam int PS2_DATA_W   = 8;
  localparam int PS2_CH_KBD   = 0;
  localparam int PS2_CH_MOUSE = 1;

  typedef struct packed {
    logic                  err;
    logic [PS2_DATA_W-1:0] code;
  } ps2_entry_t;

  function automatic int ps2_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ps2_aw(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/ps2_ch_fifo.sv
// One per-channel event FIFO: register array, wrapping pointers,
// fill count and sticky overflow.
import ps2_pkg::*;

module ps2_ch_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int AW     = ps2_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          push_i,
  input  logic [DATA_W:0] wdata_i,
  input  logic          pop_i,
  input  logic          ovf_clr_i,
  output logic [DATA_W:0] rdata_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          ovf_o
);

  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full, empty;
  logic            do_push, do_pop, drop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign drop    = push_i & full & ~do_pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (ovf_clr_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = empty;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ps2_event_queue.sv
// Multi-channel PS/2 receive queue: one FIFO per decoder,
// drained by the CPU through a single registered read port.
import ps2_pkg::*;

module ps2_event_queue #(
  parameter  int NUM_CH = 2,
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int CH_W   = ps2_ch_w(NUM_CH),
  localparam int AW     = ps2_aw(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic [NUM_CH*DATA_W-1:0] code_i,
  input  logic [NUM_CH-1:0]        strobe_i,
  input  logic [NUM_CH-1:0]        err_i,
  input  logic                     rd_i,
  input  logic [CH_W-1:0]          rd_ch_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_err_o,
  output logic                     rd_valid_o,
  output logic [NUM_CH-1:0]        avail_o,
  output logic [NUM_CH*(AW+1)-1:0] count_o,
  output logic [NUM_CH-1:0]        ovf_o,
  input  logic [NUM_CH-1:0]        ovf_clr_i
);

  logic [DATA_W:0]   head [NUM_CH];
  logic [NUM_CH-1:0] pop_req;
  logic [NUM_CH-1:0] empty;
  logic              sel_ok;
  logic              popped;
  logic [DATA_W:0]   sel_head;
  logic [DATA_W:0]   rd_q, rd_d;
  logic              vld_q;

  assign sel_ok = ({1'b0, rd_ch_i} < (CH_W+1)'(NUM_CH));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign pop_req[k] = rd_i & sel_ok & (rd_ch_i == CH_W'(k));

    ps2_ch_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .push_i    (strobe_i[k]),
      .wdata_i   ({err_i[k], code_i[k*DATA_W +: DATA_W]}),
      .pop_i     (pop_req[k]),
      .ovf_clr_i (ovf_clr_i[k]),
      .rdata_o   (head[k]),
      .count_o   (count_o[k*(AW+1) +: AW+1]),
      .empty_o   (empty[k]),
      .ovf_o     (ovf_o[k])
    );
  end

  assign avail_o = ~empty;
  assign popped  = |(pop_req & ~empty);

  always_comb begin
    sel_head = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch_i == CH_W'(k)) sel_head = head[k];
    end
  end

  // Output register holds the last popped entry until the next pop.
  assign rd_d = popped ? sel_head : rd_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      vld_q <= popped;
    end
  end

  assign rd_data_o  = rd_q[DATA_W-1:0];
  assign rd_err_o   = rd_q[DATA_W];
  assign rd_valid_o = vld_q;

endmodule

// File: tb/tb_ps2_event_queue.sv
// Randomized bench for ps2_event_queue against a queue-based
// model, plus directed fill/overflow/reset scenarios.
module tb_ps2_event_queue;
  import ps2_pkg::*;

  localparam int NC = 3;
  localparam int D  = 16;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic [NC*DW-1:0]  code_i;
  logic [NC-1:0]     strobe_i;
  logic [NC-1:0]     err_i;
  logic              rd_i;
  logic [CW-1:0]     rd_ch_i;
  logic [DW-1:0]     rd_data_o;
  logic              rd_err_o;
  logic              rd_valid_o;
  logic [NC-1:0]     avail_o;
  logic [NC*(AW+1)-1:0] count_o;
  logic [NC-1:0]     ovf_o;
  logic [NC-1:0]     ovf_clr_i;

  always #5 clk = ~clk;

  ps2_event_queue #(
    .NUM_CH (NC),
    .DEPTH  (D),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .code_i     (code_i),
    .strobe_i   (strobe_i),
    .err_i      (err_i),
    .rd_i       (rd_i),
    .rd_ch_i    (rd_ch_i),
    .rd_data_o  (rd_data_o),
    .rd_err_o   (rd_err_o),
    .rd_valid_o (rd_valid_o),
    .avail_o    (avail_o),
    .count_o    (count_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  ps2_entry_t    mq [NC][$];
  logic [NC-1:0] mov;
  logic          mvld;
  ps2_entry_t    mrd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    strobe_i  = '0;
    code_i    = '0;
    err_i     = '0;
    rd_i      = 1'b0;
    rd_ch_i   = '0;
    ovf_clr_i = '0;
  endtask

  function automatic logic [4:0] cnt(input int k);
    return count_o[k*(AW+1) +: AW+1];
  endfunction

  function automatic logic [NC*DW-1:0] at(input int k,
                                          input logic [7:0] v);
    logic [NC*DW-1:0] r;
    r = '0;
    r[k*DW +: DW] = v;
    return r;
  endfunction

  task automatic check_all();
    chk("rd_valid", {31'b0, rd_valid_o}, {31'b0, mvld});
    chk("rd_data", {24'b0, rd_data_o}, {24'b0, mrd.code});
    chk("rd_err", {31'b0, rd_err_o}, {31'b0, mrd.err});
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("count%0d", k), {27'b0, cnt(k)},
          mq[k].size());
      chk($sformatf("avail%0d", k), {31'b0, avail_o[k]},
          (mq[k].size() != 0) ? 32'd1 : 32'd0);
      chk($sformatf("ovf%0d", k), {31'b0, ovf_o[k]},
          {31'b0, mov[k]});
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) mq[k].delete();
    mov  = '0;
    mvld = 1'b0;
    mrd  = '0;
  endtask

  task automatic cyc(input logic [NC-1:0]    stb,
                     input logic [NC*DW-1:0] code,
                     input logic [NC-1:0]    err,
                     input logic             rd,
                     input logic [CW-1:0]    ch,
                     input logic [NC-1:0]    clr);
    logic       popped;
    ps2_entry_t h;
    strobe_i  = stb;
    code_i    = code;
    err_i     = err;
    rd_i      = rd;
    rd_ch_i   = ch;
    ovf_clr_i = clr;
    popped    = 1'b0;
    h         = '0;
    for (int k = 0; k < NC; k++) begin
      if (rd && int'(ch) == k && mq[k].size() > 0) begin
        h = mq[k].pop_front();
        popped = 1'b1;
      end
      if (clr[k]) mov[k] = 1'b0;
      if (stb[k]) begin
        if (mq[k].size() < D)
          mq[k].push_back({err[k], code[k*DW +: DW]});
        else
          mov[k] = 1'b1;
      end
    end
    mvld = popped;
    if (popped) mrd = h;
    @(posedge clk);
    #1;
    idle();
    check_all();
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    check_all();

    // 1: single push/pop
    cyc(3'b001, at(0, 8'h1C), '0, 0, 0, '0);
    chk("t1_avail", {29'b0, avail_o}, 32'h1);
    chk("t1_count0", {27'b0, cnt(0)}, 32'd1);
    cyc('0, '0, '0, 1, 0, '0);
    chk("t1_valid", {31'b0, rd_valid_o}, 32'd1);
    chk("t1_data", {24'b0, rd_data_o}, 32'h1C);
    chk("t1_avail0", {29'b0, avail_o}, 32'h0);
    cyc('0, '0, '0, 0, 0, '0);
    chk("t1_pulse", {31'b0, rd_valid_o}, 32'd0);

    // 2: overflow on ch0
    for (int i = 0; i <= 16; i++)
      cyc(3'b001, at(0, 8'(i)), '0, 0, 0, '0);
    chk("t2_ovf", {31'b0, ovf_o[0]}, 32'd1);
    chk("t2_count", {27'b0, cnt(0)}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc('0, '0, '0, 1, 0, '0);
      chk("t2_order", {24'b0, rd_data_o}, i);
    end
    cyc('0, '0, '0, 1, 0, '0);
    chk("t2_empty_pop", {31'b0, rd_valid_o}, 32'd0);
    cyc('0, '0, '0, 0, 0, 3'b001);
    chk("t2_clr", {31'b0, ovf_o[0]}, 32'd0);

    // 3: error flag on mouse channel
    cyc(3'b010, at(PS2_CH_MOUSE, 8'hF0), 3'b010, 0, 0, '0);
    cyc('0, '0, '0, 1, 1, '0);
    chk("t3_data", {24'b0, rd_data_o}, 32'hF0);
    chk("t3_err", {31'b0, rd_err_o}, 32'd1);
    chk("t3_kbd", {27'b0, cnt(PS2_CH_KBD)}, 32'd0);

    // 4: full + push + pop same cycle
    for (int i = 0; i < 16; i++)
      cyc(3'b001, at(0, 8'(8'h60 + i)), '0, 0, 0, '0);
    cyc(3'b001, at(0, 8'h55), '0, 1, 0, '0);
    chk("t4_count", {27'b0, cnt(0)}, 32'd16);
    chk("t4_ovf", {31'b0, ovf_o[0]}, 32'd0);
    chk("t4_first", {24'b0, rd_data_o}, 32'h60);
    for (int i = 0; i < 16; i++)
      cyc('0, '0, '0, 1, 0, '0);
    chk("t4_last", {24'b0, rd_data_o}, 32'h55);

    // 5: empty push+pop, out-of-range channel
    cyc(3'b010, at(1, 8'h12), '0, 1, 1, '0);
    chk("t5_nobypass", {31'b0, rd_valid_o}, 32'd0);
    chk("t5_count1", {27'b0, cnt(1)}, 32'd1);
    cyc('0, '0, '0, 1, 2'd3, '0);
    chk("t5_badch", {31'b0, rd_valid_o}, 32'd0);
    cyc('0, '0, '0, 1, 1, '0);
    chk("t5_data", {24'b0, rd_data_o}, 32'h12);

    // 6: reset mid-stream
    for (int i = 0; i < 5; i++)
      cyc(3'b001, at(0, 8'(8'h30 + i)), '0, 0, 0, '0);
    strobe_i = 3'b001;
    code_i   = at(0, 8'h77);
    @(negedge clk);
    reset_n_i = 1'b0;
    #1;
    model_reset();
    chk("t6_count0", {27'b0, cnt(0)}, 32'd0);
    chk("t6_data", {24'b0, rd_data_o}, 32'd0);
    check_all();
    @(negedge clk);
    idle();
    @(negedge clk);
    reset_n_i = 1'b1;
    cyc('0, '0, '0, 1, 0, '0);
    chk("t6_pop", {31'b0, rd_valid_o}, 32'd0);

    // random traffic: fill-heavy, then drain-heavy
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        logic [NC-1:0]    stb, err, clr;
        logic [NC*DW-1:0] code;
        for (int k = 0; k < NC; k++) begin
          stb[k] = ($urandom_range(0, 9) < (ph == 0 ? 5 : 2));
          err[k] = $urandom_range(0, 3) == 0;
          clr[k] = $urandom_range(0, 19) == 0;
          code[k*DW +: DW] = 8'($urandom);
        end
        cyc(stb, code, err,
            $urandom_range(0, 9) < (ph == 0 ? 4 : 9),
            2'($urandom_range(0, 3)), clr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
